proc_issue_arb: RTL

PROC_ISSUE_ARB -- requirements
Module: proc_issue_arb

---
 rtl/proc_issue_arb_if.sv | 38 +++
 rtl/proc_issue_arb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/proc_issue_arb_if.sv
// Issue-arbiter bundle: two requester queues feeding one processor command port.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface proc_issue_arb_if;
  logic       req0_valid;
  logic       req1_valid;
  logic       req0_ready;
  logic       req1_ready;
  logic [5:0] req0_instr;
  logic [5:0] req1_instr;
  logic [7:0] req0_data;
  logic [7:0] req1_data;
  logic       proc_w;
  logic [1:0] proc_F;
  logic [1:0] proc_Rx;
  logic [1:0] proc_Ry;
  logic [7:0] ext_data;
  logic       proc_done;
  logic       cmp_valid;
  logic       cmp_id;
  logic       busy;
  logic       err;

  modport slave (
    input  req0_valid, req1_valid, req0_instr, req1_instr, req0_data, req1_data,
    input  proc_done,
    output req0_ready, req1_ready,
    output proc_w, proc_F, proc_Rx, proc_Ry, ext_data,
    output cmp_valid, cmp_id, busy, err
  );

  modport master (
    output req0_valid, req1_valid, req0_instr, req1_instr, req0_data, req1_data,
    output proc_done,
    input  req0_ready, req1_ready,
    input  proc_w, proc_F, proc_Rx, proc_Ry, ext_data,
    input  cmp_valid, cmp_id, busy, err
  );
endinterface

// File: rtl/proc_issue_arb.sv
// proc_issue_arb: two requesters, each with a 2-entry {instr,data} queue, share one
// processor. A round-robin grant pops one head into a command register, which is
// issued with a one-cycle proc_w, held through WAIT until proc_done, and followed
// by a one-cycle GAP. Completion is reported with cmp_valid/cmp_id.
// Optional feature: define PROC_ARB_TIMEOUT_EN to abort a WAIT after 15 cycles
// without proc_done, pulsing err instead of cmp_valid.
module proc_issue_arb (
  input  logic              clk,
  input  logic              rst,
  proc_issue_arb_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_e;

  state_e      state_q;
  state_e      state_d;

  logic [1:0]  req_valid;
  logic [5:0]  req_instr [2];
  logic [7:0]  req_data  [2];

  logic        ready_en;
  logic [13:0] fifo_mem  [2][2];
  logic [1:0]  fifo_cnt  [2];
  logic [1:0]  fifo_rd;
  logic [1:0]  fifo_wr;
  logic [13:0] fifo_head [2];
  logic [1:0]  fifo_ne;
  logic [1:0]  req_ready;
  logic [1:0]  push;
  logic [1:0]  pop;

  logic        grant_sel;
  logic        grant_en;
  logic        last_grant;
  logic        grant_q;
  logic [13:0] cmd_q;

  logic        issue_w;
  logic        busy_o;
  logic        done_hit;
  logic        timeout_hit;
  logic        cmp_valid_q;
  logic        err_q;

  assign req_valid    = {bus.req1_valid, bus.req0_valid};
  assign req_instr[0] = bus.req0_instr;
  assign req_instr[1] = bus.req1_instr;
  assign req_data[0]  = bus.req0_data;
  assign req_data[1]  = bus.req1_data;

  // Queue status, handshakes and head-of-queue view for both requesters
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fifo_ne[i]   = (fifo_cnt[i] != 2'd0);
      req_ready[i] = ready_en && (fifo_cnt[i] != 2'd2);
      push[i]      = req_valid[i] && req_ready[i];
      pop[i]       = grant_en && (grant_sel == i[0]);
      fifo_head[i] = fifo_mem[i][fifo_rd[i]];
    end
  end

  // Round-robin pick: on a tie the requester not granted last wins
  always_comb begin
    grant_sel = 1'b0;
    if (fifo_ne[0] && fifo_ne[1]) begin
      grant_sel = ~last_grant;
    end else begin
      grant_sel = fifo_ne[1];
    end
  end

  // Ready stays low during reset and rises on the first clock afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Queue pointers and occupancy; a push and pop together leave the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_cnt[i] <= 2'd0;
      end
      fifo_rd <= 2'b00;
      fifo_wr <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          fifo_wr[i] <= ~fifo_wr[i];
        end
        if (pop[i]) begin
          fifo_rd[i] <= ~fifo_rd[i];
        end
        fifo_cnt[i] <= fifo_cnt[i] + {1'b0, push[i]} - {1'b0, pop[i]};
      end
    end
  end

  // Queue storage needs no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        fifo_mem[i][fifo_wr[i]] <= {req_instr[i], req_data[i]};
      end
    end
  end

`ifdef PROC_ARB_TIMEOUT_EN
  logic [3:0] to_cnt;

  // Count WAIT cycles without proc_done; cleared while issuing so it starts at 0 in WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= 4'd0;
    end else if (state_q == ISSUE) begin
      to_cnt <= 4'd0;
    end else if ((state_q == WAIT) && !bus.proc_done) begin
      to_cnt <= to_cnt + 4'd1;
    end
  end

  assign timeout_hit = (state_q == WAIT) && !bus.proc_done && (to_cnt == 4'd14);
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|fifo_ne) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.proc_done || timeout_hit) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded controls
  always_comb begin
    grant_en = (state_q == IDLE) && (|fifo_ne);
    issue_w  = (state_q == ISSUE);
    busy_o   = (state_q != IDLE);
    done_hit = (state_q == WAIT) && bus.proc_done;
  end

  // Command register and grant bookkeeping, loaded only at a grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q      <= 14'd0;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
    end else if (grant_en) begin
      cmd_q      <= fifo_head[grant_sel];
      grant_q    <= grant_sel;
      last_grant <= grant_sel;
    end
  end

  // Completion and timeout pulses, registered so they land in the GAP cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cmp_valid_q <= done_hit;
      err_q       <= timeout_hit;
    end
  end

  assign bus.req0_ready = req_ready[0];
  assign bus.req1_ready = req_ready[1];
  assign bus.proc_w     = issue_w;
  assign bus.proc_F     = cmd_q[13:12];
  assign bus.proc_Rx    = cmd_q[11:10];
  assign bus.proc_Ry    = cmd_q[9:8];
  assign bus.ext_data   = cmd_q[7:0];
  assign bus.cmp_valid  = cmp_valid_q;
  assign bus.cmp_id     = grant_q;
  assign bus.busy       = busy_o;
  assign bus.err        = err_q;

endmodule
